alu_seq: RTL

Parametrised, handshaked successor to the team's combinational 64-bit ALU. It accepts one operation at a time over a valid/ready input channel and computes ADD/SUB/logic in one cycle. MUL/DIV/REM run iteratively at one bit per cycle. The result and the Z/C/N/V flags are held on a valid/ready output channel. It sits between the decode stage and writeback, and replaces the combinational ALU wherever multi-cycle MUL/DIV is acceptable.

---
 rtl/alu_seq.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/SUB/logic, iterative MUL/DIV/REM.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/DIV/REM datapath; otherwise ops 2..4 report out_err.
module alu_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_c,
  output logic             out_n,
  output logic             out_v,
  output logic             out_err
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_REM = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  // EXEC is the one-cycle compute step between acceptance and DONE.
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
`ifdef ALU_SEQ_MULDIV_EN
    S_BUSY,
`endif
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, err_q, err_d;

  logic [WIDTH-1:0] fin_res;
  logic             fin_z, fin_c, fin_n, fin_v, fin_err, fin_flag_en;
  logic [WIDTH:0]   add_sum, sub_diff;

`ifdef ALU_SEQ_MULDIV_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // acc holds the product high half (MUL) or partial remainder (DIV/REM);
  // mq holds the multiplier / dividend, shifted out while the product low half
  // or quotient is shifted in.
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] step_acc, step_mq;
  logic [WIDTH:0]   mul_sum, div_rsh;
  logic [WIDTH-1:0] div_trial;
  logic             div_ge;
  logic             b_zero;

  assign b_zero = (b_q == '0);

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    div_rsh   = {acc_q, mq_q[WIDTH-1]};
    div_ge    = (div_rsh >= {1'b0, b_q});
    div_trial = div_rsh[WIDTH-1:0] - b_q;
    if (op_q == OP_MUL) begin
      step_acc = mul_sum[WIDTH:1];
      step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end else begin
      step_acc = div_ge ? div_trial : div_rsh[WIDTH-1:0];
      step_mq  = {mq_q[WIDTH-2:0], div_ge};
    end
  end
`endif

  always_comb begin
    add_sum     = {1'b0, a_q} + {1'b0, b_q};
    sub_diff    = {1'b0, a_q} - {1'b0, b_q};
    fin_res     = '0;
    fin_c       = 1'b0;
    fin_v       = 1'b0;
    fin_err     = 1'b0;
    fin_flag_en = 1'b1;
    unique case (op_q)
      OP_ADD: begin
        fin_res = add_sum[WIDTH-1:0];
        fin_c   = add_sum[WIDTH];
        fin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_res = sub_diff[WIDTH-1:0];
        fin_c   = sub_diff[WIDTH];
        fin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: fin_res = a_q & b_q;
      OP_OR:  fin_res = a_q | b_q;
      OP_XOR: fin_res = a_q ^ b_q;
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL: begin
        fin_res = mq_q;
        fin_c   = |acc_q;
      end
      OP_DIV: begin
        fin_res = b_zero ? '1 : mq_q;
        fin_err = b_zero;
      end
      OP_REM: begin
        fin_res = b_zero ? a_q : acc_q;
        fin_err = b_zero;
      end
`else
      OP_MUL, OP_DIV, OP_REM: begin
        fin_res     = '0;
        fin_err     = 1'b1;
        fin_flag_en = 1'b0;
      end
`endif
      default: fin_res = '0;
    endcase
    fin_z = fin_flag_en && (fin_res == '0);
    fin_n = fin_flag_en && fin_res[WIDTH-1];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    z_d         = z_q;
    c_d         = c_q;
    n_d         = n_q;
    v_d         = v_q;
    err_d       = err_q;
`ifdef ALU_SEQ_MULDIV_EN
    acc_d       = acc_q;
    mq_d        = mq_q;
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(in_op);
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_EXEC;
`ifdef ALU_SEQ_MULDIV_EN
          if ((in_op == OP_MUL || in_op == OP_DIV || in_op == OP_REM) && (in_b != '0)) begin
            acc_d   = '0;
            mq_d    = in_a;
            cnt_d   = CW'(WIDTH);
            state_d = S_BUSY;
          end
`endif
        end
      end
      S_EXEC: begin
        result_d    = fin_res;
        z_d         = fin_z;
        c_d         = fin_c;
        n_d         = fin_n;
        v_d         = fin_v;
        err_d       = fin_err;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_BUSY: begin
        if (cnt_q != '0) begin
          acc_d = step_acc;
          mq_d  = step_mq;
          cnt_d = cnt_q - CW'(1);
        end else begin
          result_d    = fin_res;
          z_d         = fin_z;
          c_d         = fin_c;
          n_d         = fin_n;
          v_d         = fin_v;
          err_d       = fin_err;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      acc_q       <= '0;
      mq_q        <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      z_q         <= z_d;
      c_q         <= c_d;
      n_q         <= n_d;
      v_q         <= v_d;
      err_q       <= err_d;
`ifdef ALU_SEQ_MULDIV_EN
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_z      = z_q;
  assign out_c      = c_q;
  assign out_n      = n_q;
  assign out_v      = v_q;
  assign out_err    = err_q;

endmodule
